// File: rtl/hazard_pkg.sv
// Shared defaults and the register-match rule for the hazard unit.
package hazard_pkg;
   localparam int DATA_W_D     = 32;
   localparam int REG_AW_D     = 5;
   localparam int HIST_DEPTH_D = 2;
   localparam int MUL_LAT_D    = 5;
   localparam int DIV_LAT_D    = 10;
   localparam int CNT_W_D      = 16;
   localparam int MAX_AW       = 16;

   // $0 is hardwired, so a zero destination never produces a match.
   function automatic logic match(input logic [MAX_AW-1:0] a, input logic [MAX_AW-1:0] b);
      return (a == b) && (b != '0);
   endfunction
endpackage

// File: rtl/hazard_unit_p_if.sv
// Pipeline-side bundle of the hazard unit: operands, results and control outputs.
interface hazard_unit_p_if import hazard_pkg::*; #(
   parameter int DATA_W = DATA_W_D,
   parameter int REG_AW = REG_AW_D,
   parameter int CNT_W  = CNT_W_D
);
   logic [REG_AW-1:0] A1D, A2D, A1E, A2E, A3E, A3M, A2M, A3W;
   logic [DATA_W-1:0] RD1D, RD2D, RD1E, RD2E, WDE, WDM, RD2M, WDW;
   logic              D1Use, D2Use, E1Use, E2Use, RdyE, RdyM;
   logic              MDStart, MDIsDiv, MDUseD;
   logic [DATA_W-1:0] ForwardD1, ForwardD2, ForwardE1, ForwardE2, ForwardM2;
   logic              PCEn, DRegEn, ERegEn, ERegFlush, MRegFlush, MDBusy;
   logic [CNT_W-1:0]  StallCnt;

   modport slave (
      input  A1D, A2D, A1E, A2E, A3E, A3M, A2M, A3W,
             RD1D, RD2D, RD1E, RD2E, WDE, WDM, RD2M, WDW,
             D1Use, D2Use, E1Use, E2Use, RdyE, RdyM, MDStart, MDIsDiv, MDUseD,
      output ForwardD1, ForwardD2, ForwardE1, ForwardE2, ForwardM2,
             PCEn, DRegEn, ERegEn, ERegFlush, MRegFlush, MDBusy, StallCnt
   );
   modport master (
      output A1D, A2D, A1E, A2E, A3E, A3M, A2M, A3W,
             RD1D, RD2D, RD1E, RD2E, WDE, WDM, RD2M, WDW,
             D1Use, D2Use, E1Use, E2Use, RdyE, RdyM, MDStart, MDIsDiv, MDUseD,
      input  ForwardD1, ForwardD2, ForwardE1, ForwardE2, ForwardM2,
             PCEn, DRegEn, ERegEn, ERegFlush, MRegFlush, MDBusy, StallCnt
   );
endinterface

// File: rtl/hzd_wb_history.sv
// Shift register of recent write-backs; entry 0 is the newest.
module hzd_wb_history #(
   parameter int HIST_DEPTH = 2,
   parameter int REG_AW     = 5,
   parameter int DATA_W     = 32
)(
   input  logic                              Clk,
   input  logic                              Reset,
   input  logic [REG_AW-1:0]                 a3w,
   input  logic [DATA_W-1:0]                 wdw,
   output logic [HIST_DEPTH-1:0][REG_AW-1:0] hist_a,
   output logic [HIST_DEPTH-1:0][DATA_W-1:0] hist_d
);
   // Shifts unconditionally: W retires its result whether or not earlier stages stall.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         hist_a <= '0;
         hist_d <= '0;
      end else begin
         hist_a[0] <= a3w;
         hist_d[0] <= wdw;
         for (int i = 1; i < HIST_DEPTH; i++) begin
            hist_a[i] <= hist_a[i-1];
            hist_d[i] <= hist_d[i-1];
         end
      end
   end
endmodule

// File: rtl/hazard_unit_p.sv
// Pipeline hazard unit: operand forwarding, load/MD stall control and stall statistics.
module hazard_unit_p import hazard_pkg::*; #(
   parameter int DATA_W     = DATA_W_D,
   parameter int REG_AW     = REG_AW_D,
   parameter int HIST_DEPTH = HIST_DEPTH_D,
   parameter int MUL_LAT    = MUL_LAT_D,
   parameter int DIV_LAT    = DIV_LAT_D,
   parameter int CNT_W      = CNT_W_D
)(
   input  logic           Clk,
   input  logic           Reset,
   hazard_unit_p_if.slave hif
);
   localparam int MD_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int MD_W   = $clog2(MD_MAX + 1);

   logic [HIST_DEPTH-1:0][REG_AW-1:0] hist_a;
   logic [HIST_DEPTH-1:0][DATA_W-1:0] hist_d;
   logic [DATA_W-1:0] fwd_e1, fwd_e2, fwd_m2;
   logic [MD_W-1:0]   md_cnt;
   logic [CNT_W-1:0]  stall_cnt;
   logic              md_busy, stall_e, stall_d, stall_d_raw, pc_en;
   logic              d1e, d2e, d1m, d2m;

   function automatic logic m(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
      return match(MAX_AW'(a), MAX_AW'(b));
   endfunction

   hzd_wb_history #(.HIST_DEPTH(HIST_DEPTH), .REG_AW(REG_AW), .DATA_W(DATA_W)) u_hist (
      .Clk(Clk), .Reset(Reset), .a3w(hif.A3W), .wdw(hif.WDW),
      .hist_a(hist_a), .hist_d(hist_d)
   );

   assign hif.ForwardD1 = m(hif.A1D, hif.A3E) ? hif.WDE : m(hif.A1D, hif.A3M) ? hif.WDM : hif.RD1D;
   assign hif.ForwardD2 = m(hif.A2D, hif.A3E) ? hif.WDE : m(hif.A2D, hif.A3M) ? hif.WDM : hif.RD2D;

   // Lowest priority applied first so newer sources overwrite older ones.
   always_comb begin
      fwd_e1 = hif.RD1E;
      fwd_e2 = hif.RD2E;
      fwd_m2 = hif.RD2M;
      for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
         if (m(hif.A1E, hist_a[i])) fwd_e1 = hist_d[i];
         if (m(hif.A2E, hist_a[i])) fwd_e2 = hist_d[i];
      end
      if (m(hif.A2M, hist_a[0])) fwd_m2 = hist_d[0];
      if (m(hif.A1E, hif.A3W))   fwd_e1 = hif.WDW;
      if (m(hif.A2E, hif.A3W))   fwd_e2 = hif.WDW;
      if (m(hif.A2M, hif.A3W))   fwd_m2 = hif.WDW;
      if (m(hif.A1E, hif.A3M))   fwd_e1 = hif.WDM;
      if (m(hif.A2E, hif.A3M))   fwd_e2 = hif.WDM;
   end

   assign hif.ForwardE1 = fwd_e1;
   assign hif.ForwardE2 = fwd_e2;
   assign hif.ForwardM2 = fwd_m2;

   assign stall_e = !hif.RdyM & ((hif.E1Use & m(hif.A1E, hif.A3M)) |
                                 (hif.E2Use & m(hif.A2E, hif.A3M)));

   // An E match shadows an M match for the same source: E holds the newer value.
   assign d1e = hif.D1Use & m(hif.A1D, hif.A3E);
   assign d2e = hif.D2Use & m(hif.A2D, hif.A3E);
   assign d1m = hif.D1Use & m(hif.A1D, hif.A3M) & !m(hif.A1D, hif.A3E);
   assign d2m = hif.D2Use & m(hif.A2D, hif.A3M) & !m(hif.A2D, hif.A3E);

   assign stall_d_raw = ((d1e | d2e) & !hif.RdyE) | ((d1m | d2m) & !hif.RdyM) |
                        (hif.MDUseD & (hif.MDStart | md_busy));
   assign stall_d     = stall_d_raw & !stall_e;
   assign pc_en       = !(stall_d | stall_e);

   assign hif.PCEn      = pc_en;
   assign hif.DRegEn    = pc_en;
   assign hif.ERegEn    = !stall_e;
   assign hif.ERegFlush = stall_d;
   assign hif.MRegFlush = stall_e;
   assign hif.MDBusy    = md_busy;
   assign hif.StallCnt  = stall_cnt;
   assign md_busy       = (md_cnt != '0);

   // An issue held in E by a stall is re-presented later, so only a moving E loads.
   always_ff @(posedge Clk) begin
      if (Reset)
         md_cnt <= '0;
      else if (hif.MDStart && !stall_e)
         md_cnt <= hif.MDIsDiv ? MD_W'(DIV_LAT) : MD_W'(MUL_LAT);
      else if (md_busy)
         md_cnt <= md_cnt - MD_W'(1);
   end

   always_ff @(posedge Clk) begin
      if (Reset)
         stall_cnt <= '0;
      else if (!pc_en && stall_cnt != '1)
         stall_cnt <= stall_cnt + CNT_W'(1);
   end
endmodule

// File: tb/tb_hazard_unit_p.sv
// Scenario bench for hazard_unit_p with a queue of expected output snapshots.
module tb_hazard_unit_p;
   localparam int DW = 32;
   localparam int CW = 16;

   typedef struct packed {
      logic [DW-1:0] fd1, fd2, fe1, fe2, fm2;
      logic          pcen, dregen, eregen, eflush, mflush, mdbusy;
      logic [CW-1:0] sc;
   } obs_t;
   typedef struct { string nm; obs_t v; } sb_t;

   logic Clk = 1'b0;
   logic Reset = 1'b0;
   always #5 Clk = ~Clk;

   hazard_unit_p_if hif();
   hazard_unit_p dut (.Clk(Clk), .Reset(Reset), .hif(hif));

   sb_t exp_q[$];
   int  n_chk = 0;
   int  n_pass = 0;

   function automatic obs_t observe();
      obs_t o;
      o.fd1 = hif.ForwardD1; o.fd2 = hif.ForwardD2;
      o.fe1 = hif.ForwardE1; o.fe2 = hif.ForwardE2; o.fm2 = hif.ForwardM2;
      o.pcen = hif.PCEn; o.dregen = hif.DRegEn; o.eregen = hif.ERegEn;
      o.eflush = hif.ERegFlush; o.mflush = hif.MRegFlush; o.mdbusy = hif.MDBusy;
      o.sc = hif.StallCnt;
      return o;
   endfunction

   function automatic obs_t base(input logic [CW-1:0] sc);
      obs_t o;
      o.fd1 = 32'h11; o.fd2 = 32'h22; o.fe1 = 32'h33; o.fe2 = 32'h44; o.fm2 = 32'h55;
      o.pcen = 1'b1; o.dregen = 1'b1; o.eregen = 1'b1;
      o.eflush = 1'b0; o.mflush = 1'b0; o.mdbusy = 1'b0;
      o.sc = sc;
      return o;
   endfunction

   task automatic idle();
      hif.A1D = '0; hif.A2D = '0; hif.A1E = '0; hif.A2E = '0;
      hif.A3E = '0; hif.A3M = '0; hif.A2M = '0; hif.A3W = '0;
      hif.RD1D = 32'h11; hif.RD2D = 32'h22; hif.RD1E = 32'h33; hif.RD2E = 32'h44;
      hif.RD2M = 32'h55; hif.WDE = 32'hE0; hif.WDM = 32'hA0; hif.WDW = 32'hB0;
      hif.D1Use = 0; hif.D2Use = 0; hif.E1Use = 0; hif.E2Use = 0;
      hif.RdyE = 1; hif.RdyM = 1; hif.MDStart = 0; hif.MDIsDiv = 0; hif.MDUseD = 0;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      idle();
      Reset = 1'b1;
      @(posedge Clk);
      #1 Reset = 1'b0;
   endtask

   task automatic test_reset();
      sb_t s; obs_t act;
      @(negedge Clk);
      idle();
      hif.MDStart = 1; hif.MDIsDiv = 1;
      do_reset();
      @(negedge Clk);
      s.nm = "reset"; s.v = base(0);
      exp_q.push_back(s);
      #1 act = observe(); s = exp_q.pop_front(); n_chk++;
      if (act !== s.v) $display("FAIL %s: got %h want %h", s.nm, act, s.v);
      else n_pass++;
   endtask

   task automatic test_stall_d();
      sb_t s; obs_t e, act;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         @(negedge Clk);
         idle();
         case (k)
            0: begin
               hif.A3E = 8; hif.RdyE = 0; hif.A1D = 8; hif.D1Use = 1;
               e = base(0); e.fd1 = 32'hE0; e.pcen = 0; e.dregen = 0; e.eflush = 1;
            end
            1: begin
               hif.A3M = 8; hif.RdyM = 0; hif.A1D = 8; hif.D1Use = 1;
               e = base(1); e.fd1 = 32'hA0; e.pcen = 0; e.dregen = 0; e.eflush = 1;
            end
            2: begin
               hif.A3M = 8; hif.A1D = 8; hif.D1Use = 1;
               e = base(2); e.fd1 = 32'hA0;
            end
            3: begin
               hif.A3E = 8; hif.RdyE = 0; hif.A2D = 8;
               e = base(2); e.fd2 = 32'hE0;
            end
            default: begin
               hif.A3E = 8; hif.A3M = 8; hif.RdyM = 0; hif.A2D = 8; hif.D2Use = 1;
               e = base(2); e.fd2 = 32'hE0;
            end
         endcase
         s.nm = $sformatf("stall_d_%0d", k); s.v = e;
         exp_q.push_back(s);
         #1 act = observe(); s = exp_q.pop_front(); n_chk++;
         if (act !== s.v) $display("FAIL %s: got %h want %h", s.nm, act, s.v);
         else n_pass++;
      end
   endtask

   task automatic test_stall_e();
      sb_t s; obs_t e, act;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         idle();
         hif.A3M = 9; hif.RdyM = 0;
         e = base(CW'(k));
         if (k == 0) begin
            hif.A1E = 9; hif.E1Use = 1; hif.A1D = 9; hif.D1Use = 1;
            e.fe1 = 32'hA0; e.fd1 = 32'hA0;
         end else if (k == 1) begin
            hif.A2E = 9; hif.E2Use = 1;
            e.fe2 = 32'hA0;
         end else begin
            hif.A1E = 9; hif.A2E = 9;
            e.fe1 = 32'hA0; e.fe2 = 32'hA0;
         end
         if (k < 2) begin
            e.pcen = 0; e.dregen = 0; e.eregen = 0; e.mflush = 1;
         end
         s.nm = $sformatf("stall_e_%0d", k); s.v = e;
         exp_q.push_back(s);
         #1 act = observe(); s = exp_q.pop_front(); n_chk++;
         if (act !== s.v) $display("FAIL %s: got %h want %h", s.nm, act, s.v);
         else n_pass++;
      end
   endtask

   task automatic test_history();
      sb_t s; obs_t e, act;
      do_reset();
      for (int k = 0; k < 7; k++) begin
         @(negedge Clk);
         idle();
         e = base(0);
         case (k)
            0: begin
               hif.A3W = 5; hif.WDW = 32'h1234; hif.A1E = 5; hif.A2M = 5;
               e.fe1 = 32'h1234; e.fm2 = 32'h1234;
            end
            1: begin
               hif.A1E = 5; hif.A2M = 5;
               e.fe1 = 32'h1234; e.fm2 = 32'h1234;
            end
            2: begin
               hif.A1E = 5; hif.A2M = 5;
               e.fe1 = 32'h1234;
            end
            3: hif.A1E = 5;
            4: begin
               hif.A3W = 5; hif.WDW = 32'h77; hif.A3M = 5; hif.A1E = 5;
               e.fe1 = 32'hA0;
            end
            5: begin
               hif.A3W = 5; hif.WDW = 32'h66; hif.A2E = 5; hif.A2M = 5;
               e.fe2 = 32'h66; e.fm2 = 32'h66;
            end
            default: begin
               hif.A2E = 5; hif.A2M = 5;
               e.fe2 = 32'h66; e.fm2 = 32'h66;
            end
         endcase
         s.nm = $sformatf("history_%0d", k); s.v = e;
         exp_q.push_back(s);
         #1 act = observe(); s = exp_q.pop_front(); n_chk++;
         if (act !== s.v) $display("FAIL %s: got %h want %h", s.nm, act, s.v);
         else n_pass++;
      end
   endtask

   task automatic test_zero();
      sb_t s; obs_t act;
      do_reset();
      @(negedge Clk);
      idle();
      hif.E1Use = 1; hif.E2Use = 1; hif.D1Use = 1; hif.D2Use = 1;
      hif.RdyM = 0; hif.RdyE = 0;
      s.nm = "zero_reg"; s.v = base(0);
      exp_q.push_back(s);
      #1 act = observe(); s = exp_q.pop_front(); n_chk++;
      if (act !== s.v) $display("FAIL %s: got %h want %h", s.nm, act, s.v);
      else n_pass++;
   endtask

   task automatic test_md_div();
      sb_t s; obs_t e, act;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         @(negedge Clk);
         idle();
         hif.MDUseD = 1;
         if (k == 0) begin hif.MDStart = 1; hif.MDIsDiv = 1; end
         e = base(CW'(k));
         if (k < 11) begin e.pcen = 0; e.dregen = 0; e.eflush = 1; end
         e.mdbusy = (k >= 1 && k <= 10);
         s.nm = $sformatf("md_div_%0d", k); s.v = e;
         exp_q.push_back(s);
         #1 act = observe(); s = exp_q.pop_front(); n_chk++;
         if (act !== s.v) $display("FAIL %s: got %h want %h", s.nm, act, s.v);
         else n_pass++;
      end
   endtask

   task automatic test_md_mul();
      sb_t s; obs_t e, act;
      do_reset();
      for (int k = 0; k < 17; k++) begin
         @(negedge Clk);
         idle();
         e = base((k == 0) ? CW'(0) : CW'(1));
         if (k == 0) begin
            hif.A3M = 9; hif.RdyM = 0; hif.A1E = 9; hif.E1Use = 1;
            hif.MDStart = 1; hif.MDIsDiv = 1;
            e.fe1 = 32'hA0; e.pcen = 0; e.dregen = 0; e.eregen = 0; e.mflush = 1;
         end
         if (k == 1 || k == 8 || k == 10) hif.MDStart = 1;
         e.mdbusy = (k >= 2 && k <= 6) || (k >= 9 && k <= 15);
         s.nm = $sformatf("md_mul_%0d", k); s.v = e;
         exp_q.push_back(s);
         #1 act = observe(); s = exp_q.pop_front(); n_chk++;
         if (act !== s.v) $display("FAIL %s: got %h want %h", s.nm, act, s.v);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_div();
      sb_t s; obs_t e, act;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         idle();
         if (k < 3) begin
            hif.MDUseD = 1;
            if (k == 0) begin hif.MDStart = 1; hif.MDIsDiv = 1; end
            e = base(CW'(k));
            e.pcen = 0; e.dregen = 0; e.eflush = 1; e.mdbusy = (k != 0);
         end else begin
            Reset = 1'b1;
            @(posedge Clk);
            #1 Reset = 1'b0;
            @(negedge Clk);
            e = base(0);
         end
         s.nm = $sformatf("reset_mid_div_%0d", k); s.v = e;
         exp_q.push_back(s);
         #1 act = observe(); s = exp_q.pop_front(); n_chk++;
         if (act !== s.v) $display("FAIL %s: got %h want %h", s.nm, act, s.v);
         else n_pass++;
      end
   endtask

   task automatic test_stall_sat();
      sb_t s; obs_t e, act;
      do_reset();
      @(negedge Clk);
      idle();
      hif.A3M = 9; hif.RdyM = 0; hif.A1E = 9; hif.E1Use = 1;
      for (int k = 0; k < 2; k++) begin
         repeat ((k == 0) ? 65534 : 5) @(posedge Clk);
         @(negedge Clk);
         e = base((k == 0) ? 16'hFFFE : 16'hFFFF);
         e.fe1 = 32'hA0; e.pcen = 0; e.dregen = 0; e.eregen = 0; e.mflush = 1;
         s.nm = $sformatf("stall_sat_%0d", k); s.v = e;
         exp_q.push_back(s);
         #1 act = observe(); s = exp_q.pop_front(); n_chk++;
         if (act !== s.v) $display("FAIL %s: got %h want %h", s.nm, act, s.v);
         else n_pass++;
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_stall_d();
      test_stall_e();
      test_history();
      test_zero();
      test_md_div();
      test_md_mul();
      test_reset_mid_div();
      test_stall_sat();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
